// File: rtl/regfile_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : regfile_pkg                                                     |
// | Purpose  : Shared definitions for the multi-port register file and the     |
// |            issue stage: default geometry, address-width derivation and     |
// |            the write-port priority pick (highest matching index wins).     |
// | Ports    : none (package)                                                  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package regfile_pkg;

  localparam int DW_DEFAULT    = 32;
  localparam int DEPTH_DEFAULT = 32;

  // Upper bound on write ports understood by highest_set(); callers
  // zero-extend their hit vector to this width.
  localparam int MAX_WR_PORTS  = 16;

  // Address width for a register array of the given depth (depth >= 2).
  function automatic int addr_width(input int depth);
    return $clog2(depth);
  endfunction

  // Index of the highest set bit, or -1 when no bit is set. Used to select
  // the winning write port when several ports target the same register.
  function automatic int highest_set(input logic [MAX_WR_PORTS-1:0] hits);
    int idx;
    idx = -1;
    for (int k = 0; k < MAX_WR_PORTS; k++) begin
      if (hits[k]) begin
        idx = k;
      end
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rf_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : rf_scoreboard                                                   |
// | Purpose  : Busy-bit array for the register file. A register is reserved   |
// |            at issue and released by its writeback; flush clears all.       |
// | Ports    : clk, rst_n          clock, async active-low reset               |
// |            wr_en/wr_addr       writeback ports (clear busy)                |
// |            rsv_en/rsv_addr     reservation from issue (set busy)           |
// |            flush               clear every busy bit                        |
// |            rd_addr             lookup addresses, one per read port         |
// |            rd_fwd              read port is being served by bypass         |
// |            rd_busy             busy flag per read port                     |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int DEPTH    = DEPTH_DEFAULT,
  parameter int AW       = addr_width(DEPTH_DEFAULT),
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_WR-1:0]    wr_en,
  input  logic [NUM_WR*AW-1:0] wr_addr,
  input  logic                 rsv_en,
  input  logic [AW-1:0]        rsv_addr,
  input  logic                 flush,
  input  logic [NUM_RD*AW-1:0] rd_addr,
  input  logic [NUM_RD-1:0]    rd_fwd,
  output logic [NUM_RD-1:0]    rd_busy
);

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;
  logic [DEPTH-1:0] wr_clr;
  logic [DEPTH-1:0] rsv_set;

  // Priority: flush > reservation > writeback clear > hold. The reservation
  // beats a same-cycle write because it names a newer producer.
  always_comb begin
    wr_clr  = '0;
    rsv_set = '0;
    for (int w = 0; w < NUM_WR; w++) begin
      if (wr_en[w]) begin
        wr_clr[wr_addr[w*AW +: AW]] = 1'b1;
      end
    end
    if (rsv_en) begin
      rsv_set[rsv_addr] = 1'b1;
    end
    if (ZERO_REG != 0) begin
      rsv_set[0] = 1'b0;
    end

    if (flush) begin
      busy_d = '0;
    end else begin
      busy_d = rsv_set | (busy_q & ~wr_clr);
    end
    if (ZERO_REG != 0) begin
      busy_d[0] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // A read served by bypass already sees the fresh value, so it is not busy.
  for (genvar i = 0; i < NUM_RD; i++) begin : g_lookup
    logic [AW-1:0] addr;
    assign addr       = rd_addr[i*AW +: AW];
    assign rd_busy[i] = busy_q[addr] && !rd_fwd[i] &&
                        !((ZERO_REG != 0) && (addr == '0));
  end

endmodule
`default_nettype wire

// File: rtl/register_file_mp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : register_file_mp                                                |
// | Purpose  : Multi-port register file with optional hardwired zero register, |
// |            optional write->read bypass and a per-register busy scoreboard. |
// | Ports    : clk, rst_n          clock, async active-low reset               |
// |            rd_addr/rd_data     NUM_RD combinational read ports             |
// |            rd_busy             reservation outstanding for read register   |
// |            wr_en/addr/data     NUM_WR write ports, higher index wins       |
// |            rsv_en/rsv_addr     reserve a register at issue                 |
// |            flush               drop all reservations                       |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module register_file_mp
  import regfile_pkg::*;
#(
  parameter  int DW       = DW_DEFAULT,
  parameter  int DEPTH    = DEPTH_DEFAULT,
  parameter  int NUM_RD   = 2,
  parameter  int NUM_WR   = 2,
  parameter  int ZERO_REG = 1,
  parameter  int BYPASS   = 1,
  localparam int AW       = addr_width(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_RD*AW-1:0] rd_addr,
  output logic [NUM_RD*DW-1:0] rd_data,
  output logic [NUM_RD-1:0]    rd_busy,
  input  logic [NUM_WR-1:0]    wr_en,
  input  logic [NUM_WR*AW-1:0] wr_addr,
  input  logic [NUM_WR*DW-1:0] wr_data,
  input  logic                 rsv_en,
  input  logic [AW-1:0]        rsv_addr,
  input  logic                 flush
);

  logic [DW-1:0]     mem_q [DEPTH];
  logic [DW-1:0]     mem_d [DEPTH];
  logic [NUM_RD-1:0] rd_fwd;

  // Ports are applied in ascending order so the highest-index port's data
  // is what lands when several ports hit one register.
  always_comb begin
    mem_d = mem_q;
    for (int w = 0; w < NUM_WR; w++) begin
      if (wr_en[w] && !((ZERO_REG != 0) && (wr_addr[w*AW +: AW] == '0))) begin
        mem_d[wr_addr[w*AW +: AW]] = wr_data[w*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < DEPTH; r++) begin
        mem_q[r] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [AW-1:0]           addr;
    logic [MAX_WR_PORTS-1:0] hits;
    logic [DW-1:0]           data;
    logic                    fwd;
    int                      pick;

    always_comb begin
      addr = rd_addr[i*AW +: AW];
      hits = '0;
      for (int w = 0; w < NUM_WR; w++) begin
        hits[w] = wr_en[w] && (wr_addr[w*AW +: AW] == addr);
      end
      pick = highest_set(hits);

      data = mem_q[addr];
      fwd  = 1'b0;
      if ((BYPASS != 0) && (pick >= 0)) begin
        data = wr_data[pick*DW +: DW];
        fwd  = 1'b1;
      end
      // Reset gating also blocks the bypass path, which would otherwise leak
      // live write data onto the read port while reset is held.
      if (((ZERO_REG != 0) && (addr == '0)) || !rst_n) begin
        data = '0;
      end
    end

    assign rd_data[i*DW +: DW] = data;
    assign rd_fwd[i]           = fwd;
  end

  rf_scoreboard #(
    .DEPTH    (DEPTH),
    .AW       (AW),
    .NUM_RD   (NUM_RD),
    .NUM_WR   (NUM_WR),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .flush    (flush),
    .rd_addr  (rd_addr),
    .rd_fwd   (rd_fwd),
    .rd_busy  (rd_busy)
  );

endmodule
`default_nettype wire

// File: tb/tb_register_file_mp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_register_file_mp                                             |
// | Purpose  : Scoreboard bench for register_file_mp. Two instances share all  |
// |            inputs: inst 0 with bypass, inst 1 without. Directed vectors    |
// |            with hand-computed values, then a random phase against a model. |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_register_file_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int NW = 2;

  logic           clk;
  logic           rst_n;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data_b;
  logic [NR*DW-1:0] rd_data_n;
  logic [NR-1:0]    rd_busy_b;
  logic [NR-1:0]    rd_busy_n;
  logic [NW-1:0]    wr_en;
  logic [NW*AW-1:0] wr_addr;
  logic [NW*DW-1:0] wr_data;
  logic             rsv_en;
  logic [AW-1:0]    rsv_addr;
  logic             flush;

  register_file_mp #(.BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_b),
    .rd_busy(rd_busy_b), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .flush(flush)
  );

  register_file_mp #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_n),
    .rd_busy(rd_busy_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .flush(flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    int          tag;
    int          inst;
    int          port;
    logic [31:0] data;
    logic        busy;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // ---------------- scoreboard monitor ----------------
  initial begin
    exp_t        e;
    logic [31:0] got_d;
    logic        got_b;
    forever begin
      @(negedge clk);
      #2;
      while (exp_q.size() > 0) begin
        e     = exp_q.pop_front();
        got_d = (e.inst == 0) ? rd_data_b[e.port*DW +: DW] : rd_data_n[e.port*DW +: DW];
        got_b = (e.inst == 0) ? rd_busy_b[e.port] : rd_busy_n[e.port];
        total++;
        if (got_d !== e.data) begin
          bad++;
          $display("FAIL data t%0d inst%0d port%0d: got %h want %h @%0t",
                   e.tag, e.inst, e.port, got_d, e.data, $time);
        end
        total++;
        if (got_b !== e.busy) begin
          bad++;
          $display("FAIL busy t%0d inst%0d port%0d: got %b want %b @%0t",
                   e.tag, e.inst, e.port, got_b, e.busy, $time);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    wr_en  = '0;
    rsv_en = 1'b0;
    flush  = 1'b0;
  endtask

  task automatic step();
    @(negedge clk);
    idle();
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rd_addr = {a1, a0};
  endtask

  task automatic set_wr(input int p, input logic [AW-1:0] a, input logic [31:0] d);
    wr_en[p]            = 1'b1;
    wr_addr[p*AW +: AW] = a;
    wr_data[p*DW +: DW] = d;
  endtask

  task automatic rsv(input logic [AW-1:0] a);
    rsv_en   = 1'b1;
    rsv_addr = a;
  endtask

  task automatic expect1(input int tag, input int inst, input int port,
                         input logic [31:0] d, input logic b);
    exp_t e;
    e.tag = tag; e.inst = inst; e.port = port; e.data = d; e.busy = b;
    exp_q.push_back(e);
  endtask

  task automatic expect2(input int tag, input int port, input logic [31:0] d, input logic b);
    expect1(tag, 0, port, d, b);
    expect1(tag, 1, port, d, b);
  endtask

  // ---------------- reference model for the random phase ----------------
  logic [31:0] m_mem  [32];
  logic        m_busy [32];

  task automatic model_reset();
    for (int r = 0; r < 32; r++) begin
      m_mem[r]  = '0;
      m_busy[r] = 1'b0;
    end
  endtask

  function automatic logic [31:0] model_data(input logic [AW-1:0] a, input bit byp);
    logic [31:0] d;
    d = m_mem[a];
    if (byp) begin
      for (int w = 0; w < NW; w++) begin
        if (wr_en[w] && wr_addr[w*AW +: AW] == a) d = wr_data[w*DW +: DW];
      end
    end
    if (a == 0) d = '0;
    return d;
  endfunction

  function automatic logic model_busy(input logic [AW-1:0] a, input bit byp);
    logic b;
    b = m_busy[a];
    if (byp) begin
      for (int w = 0; w < NW; w++) begin
        if (wr_en[w] && wr_addr[w*AW +: AW] == a) b = 1'b0;
      end
    end
    if (a == 0) b = 1'b0;
    return b;
  endfunction

  task automatic model_clock();
    for (int w = 0; w < NW; w++) begin
      if (wr_en[w]) begin
        if (wr_addr[w*AW +: AW] != 0) m_mem[wr_addr[w*AW +: AW]] = wr_data[w*DW +: DW];
        m_busy[wr_addr[w*AW +: AW]] = 1'b0;
      end
    end
    if (rsv_en && rsv_addr != 0) m_busy[rsv_addr] = 1'b1;
    if (flush) begin
      for (int r = 0; r < 32; r++) m_busy[r] = 1'b0;
    end
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    rst_n    = 1'b0;
    rd_addr  = '0;
    wr_addr  = '0;
    wr_data  = '0;
    rsv_addr = '0;
    idle();

    // reset state while rst_n held
    step(); set_rd(5'd5, 5'd31);
    expect2(0, 0, 32'h0, 1'b0); expect2(0, 1, 32'h0, 1'b0);
    #4 rst_n = 1'b1;

    // 1: write r5, reserve it, then async reset mid-cycle
    step(); set_wr(0, 5'd5, 32'hA5A5_0001); set_rd(5'd5, 5'd0);
    expect1(1, 0, 0, 32'hA5A5_0001, 1'b0); expect1(1, 1, 0, 32'h0, 1'b0);
    step(); rsv(5'd5); set_rd(5'd5, 5'd0);
    expect2(1, 0, 32'hA5A5_0001, 1'b0);
    step(); set_rd(5'd5, 5'd0);
    expect2(1, 0, 32'hA5A5_0001, 1'b1);
    step(); rst_n = 1'b0; set_wr(0, 5'd6, 32'hFFFF_FFFF); set_rd(5'd5, 5'd6);
    expect2(1, 0, 32'h0, 1'b0); expect2(1, 1, 32'h0, 1'b0);
    #4 rst_n = 1'b1; idle();
    step(); set_rd(5'd5, 5'd6);
    expect2(1, 0, 32'h0, 1'b0); expect2(1, 1, 32'h0, 1'b0);

    // 2: bypass vs no bypass
    step(); set_wr(0, 5'd7, 32'h1234_5678); set_rd(5'd7, 5'd7);
    expect1(2, 0, 1, 32'h1234_5678, 1'b0); expect1(2, 1, 1, 32'h0, 1'b0);
    step(); set_rd(5'd7, 5'd7);
    expect2(2, 1, 32'h1234_5678, 1'b0);

    // 3: write collision, then write to r0
    step(); set_wr(0, 5'd3, 32'h11); set_wr(1, 5'd3, 32'h22); set_rd(5'd3, 5'd0);
    expect1(3, 0, 0, 32'h22, 1'b0); expect1(3, 1, 0, 32'h0, 1'b0);
    expect2(3, 1, 32'h0, 1'b0);
    step(); set_wr(1, 5'd0, 32'hDEAD_BEEF); set_rd(5'd3, 5'd0);
    expect2(3, 0, 32'h22, 1'b0); expect2(3, 1, 32'h0, 1'b0);
    step(); set_rd(5'd3, 5'd0);
    expect2(3, 1, 32'h0, 1'b0);

    // 4: scoreboard reserve / writeback / reserve+write
    step(); rsv(5'd9); set_rd(5'd9, 5'd0);
    expect2(4, 0, 32'h0, 1'b0);
    step(); set_rd(5'd9, 5'd0);
    expect2(4, 0, 32'h0, 1'b1);
    step(); set_wr(0, 5'd9, 32'h99); set_rd(5'd9, 5'd0);
    expect1(4, 0, 0, 32'h99, 1'b0); expect1(4, 1, 0, 32'h0, 1'b1);
    step(); set_rd(5'd9, 5'd0);
    expect2(4, 0, 32'h99, 1'b0);
    step(); rsv(5'd9); set_wr(1, 5'd9, 32'hAB); set_rd(5'd9, 5'd0);
    expect1(4, 0, 0, 32'hAB, 1'b0); expect1(4, 1, 0, 32'h99, 1'b0);
    step(); set_rd(5'd9, 5'd0);
    expect2(4, 0, 32'hAB, 1'b1);

    // 5: flush beats same-cycle reserve; r0 never goes busy
    step(); rsv(5'd1);
    step(); rsv(5'd2);
    step(); rsv(5'd3); set_rd(5'd1, 5'd2);
    expect2(5, 0, 32'h0, 1'b1); expect2(5, 1, 32'h0, 1'b1);
    step(); flush = 1'b1; rsv(5'd4); set_rd(5'd3, 5'd4);
    expect2(5, 0, 32'h22, 1'b1); expect2(5, 1, 32'h0, 1'b0);
    step(); set_rd(5'd1, 5'd2);
    expect2(5, 0, 32'h0, 1'b0); expect2(5, 1, 32'h0, 1'b0);
    step(); set_rd(5'd3, 5'd4);
    expect2(5, 0, 32'h22, 1'b0); expect2(5, 1, 32'h0, 1'b0);
    step(); rsv(5'd0); set_rd(5'd9, 5'd0);
    expect2(5, 0, 32'hAB, 1'b0); expect2(5, 1, 32'h0, 1'b0);
    step(); set_rd(5'd9, 5'd0);
    expect2(5, 0, 32'hAB, 1'b0); expect2(5, 1, 32'h0, 1'b0);

    // 6: random traffic against the model, starting from a fresh reset
    step(); rst_n = 1'b0;
    #4 rst_n = 1'b1;
    model_reset();
    for (int c = 0; c < 10000; c++) begin
      logic [AW-1:0] a;
      step();
      for (int w = 0; w < NW; w++) begin
        a = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 7));
        if ($urandom_range(0, 1) == 1) set_wr(w, a, $urandom());
      end
      for (int p = 0; p < NR; p++) begin
        rd_addr[p*AW +: AW] = AW'($urandom_range(0, 7));
      end
      if ($urandom_range(0, 2) == 0) rsv(AW'($urandom_range(0, 7)));
      flush = ($urandom_range(0, 15) == 0);
      for (int p = 0; p < NR; p++) begin
        expect1(6, 0, p, model_data(rd_addr[p*AW +: AW], 1'b1), model_busy(rd_addr[p*AW +: AW], 1'b1));
        expect1(6, 1, p, model_data(rd_addr[p*AW +: AW], 1'b0), model_busy(rd_addr[p*AW +: AW], 1'b0));
      end
      model_clock();
    end

    step();
    @(negedge clk);
    #4;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
